// File: rtl/apb_pkg.sv
// Shared APB definitions: response codes, the transfer-phase state type and
// the round-robin distance helper used by the picker.
package apb_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Priority distance of requester idx when the round robin starts at ptr.
    // Distance 0 is the highest priority.
    function automatic int rr_distance(input int idx, input int ptr, input int n);
        if (idx >= ptr) begin
            return idx - ptr;
        end
        return idx + n - ptr;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: grants the eligible requester closest to
// ptr_i (inclusive, wrapping). Masked requesters never win.
module apb_rr_pick
    import apb_pkg::*;
#(
    parameter int NMST = 2,
    parameter int PW   = (NMST > 1) ? $clog2(NMST) : 1
)(
    input  logic [NMST-1:0] req_i,
    input  logic [NMST-1:0] mask_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NMST-1:0] gnt_o,
    output logic            valid_o
);

    logic [NMST-1:0] elig;
    int              best;
    int              bestDist;

    assign elig = req_i & ~mask_i;

    // Scan every requester and keep the eligible one with the smallest distance.
    always_comb begin
        best     = 0;
        bestDist = NMST;
        valid_o  = 1'b0;
        gnt_o    = '0;
        for (int i = 0; i < NMST; i++) begin
            if (elig[i] && (rr_distance(i, int'(ptr_i), NMST) < bestDist)) begin
                bestDist = rr_distance(i, int'(ptr_i), NMST);
                best     = i;
                valid_o  = 1'b1;
            end
        end
        for (int i = 0; i < NMST; i++) begin
            gnt_o[i] = valid_o && (best == i);
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin arbiter sharing one downstream APB slave between NMST upstream
// masters. Sequences SETUP/ACCESS downstream, steers the response to the
// grantee only, and terminates hung accesses with SLVERR via a watchdog.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int NMST = 2,
    parameter int AWID = 32,
    parameter int DWID = 32,
    parameter int TOUT = 255
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NMST-1:0]        m_psel,
    input  logic [NMST-1:0]        m_penable,
    input  logic [NMST-1:0]        m_pwrite,
    input  logic [NMST*AWID-1:0]   m_paddr,
    input  logic [NMST*DWID-1:0]   m_pwdata,
    input  logic [NMST*DWID/8-1:0] m_pstrb,
    output logic [DWID-1:0]        m_prdata,
    output logic [NMST-1:0]        m_pready,
    output logic [1:0]             m_presp,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [AWID-1:0]        paddr,
    output logic [DWID-1:0]        pwdata,
    output logic [DWID/8-1:0]      pstrb,
    input  logic [DWID-1:0]        prdata,
    input  logic                   pready,
    input  logic [1:0]             presp,
    output logic [NMST-1:0]        gnt,
    output logic                   timeout
);

    localparam int SW  = DWID / 8;
    localparam int PW  = (NMST > 1) ? $clog2(NMST) : 1;
    localparam int WDW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

    // The watchdog counter holds the number of ACCESS cycles already spent
    // waiting; it fires in the ACCESS cycle that would take it to TOUT.
    localparam logic [WDW-1:0] WD_LAST = (TOUT > 0) ? WDW'(TOUT - 1) : '0;
    localparam logic [WDW-1:0] WD_MAX  = '1;

    apb_state_e      state_q, state_d;
    logic [NMST-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic [PW-1:0]   gidx;
    logic [PW-1:0]   next_ptr;
    logic [NMST-1:0] pick_gnt;
    logic            pick_valid;
    logic [NMST-1:0] pick_mask;
    logic [PW-1:0]   pick_ptr;
    logic            wd_fire;
    logic            done;

    // Binary index of the one-hot grant; 0 when idle so the muxes stay defined.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NMST; i++) begin
            if (gnt_q[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign next_ptr = (gidx == PW'(NMST - 1)) ? '0 : gidx + PW'(1);

    // In the completion cycle the current grantee is masked out and the search
    // starts just after it, so back-to-back grants rotate fairly.
    assign pick_mask = (state_q == ACCESS) ? gnt_q : '0;
    assign pick_ptr  = (state_q == ACCESS) ? next_ptr : rr_ptr_q;

    apb_rr_pick #(
        .NMST (NMST),
        .PW   (PW)
    ) u_pick (
        .req_i   (m_psel),
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // A real pready always beats the watchdog in the same cycle.
    assign wd_fire = (TOUT != 0) && (state_q == ACCESS) && !pready && (wd_q == WD_LAST);
    assign done    = (state_q == ACCESS) && (pready || wd_fire);

    assign psel     = (state_q != IDLE);
    assign penable  = (state_q == ACCESS);
    assign gnt      = gnt_q;
    assign m_pready = done ? gnt_q : '0;
    assign m_prdata = prdata;
    assign m_presp  = wd_fire ? SLVERR : presp;
    assign timeout  = wd_fire;

    // Downstream command is steered combinationally from the grantee's lanes.
    always_comb begin
        pwrite = 1'b0;
        paddr  = '0;
        pwdata = '0;
        pstrb  = '0;
        for (int i = 0; i < NMST; i++) begin
            if (gidx == PW'(i)) begin
                pwrite = m_pwrite[i];
                paddr  = m_paddr[i*AWID +: AWID];
                pwdata = m_pwdata[i*DWID +: DWID];
                pstrb  = m_pstrb[i*SW +: SW];
            end
        end
    end

    // Transfer sequencing, grant handover, pointer rotation and watchdog count.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wd_d    = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    rr_ptr_d = next_ptr;
                    wd_d     = '0;
                    if (pick_valid) begin
                        gnt_d   = pick_gnt;
                        state_d = SETUP;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            wd_q     <= wd_d;
        end
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q))
        else $error("apb_master_arb: grant is not one-hot");

    a_grantee_holds_psel : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != IDLE) |-> |(m_psel & gnt_q))
        else $error("apb_master_arb: grantee dropped m_psel before completion");

    a_grantee_in_access : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ACCESS) |-> |(m_penable & gnt_q))
        else $error("apb_master_arb: grantee not in its access phase during downstream ACCESS");

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: directed transfers from two upstream
// master models, a programmable downstream slave, and a negedge monitor that
// checks grants, commands and responses against queued expectations.
`timescale 1ns/1ps
module tb_apb_master_arb;

    localparam int NMST = 2;
    localparam int AWID = 32;
    localparam int DWID = 32;
    localparam int TOUT = 4;

    typedef struct {
        logic [1:0]  gnt;
        bit          b2b;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } setupExp_t;

    typedef struct {
        logic [1:0]  rdy;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          acc;
        bit          chkData;
    } respExp_t;

    typedef struct {
        int          waitCyc;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } slaveCfg_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } mreq_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NMST-1:0]        m_psel;
    logic [NMST-1:0]        m_penable;
    logic [NMST-1:0]        m_pwrite;
    logic [NMST*AWID-1:0]   m_paddr;
    logic [NMST*DWID-1:0]   m_pwdata;
    logic [NMST*DWID/8-1:0] m_pstrb;
    logic [DWID-1:0]        m_prdata;
    logic [NMST-1:0]        m_pready;
    logic [1:0]             m_presp;
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [AWID-1:0]        paddr;
    logic [DWID-1:0]        pwdata;
    logic [DWID/8-1:0]      pstrb;
    logic [DWID-1:0]        prdata;
    logic                   pready;
    logic [1:0]             presp;
    logic [NMST-1:0]        gnt;
    logic                   timeout;

    setupExp_t setupQ[$];
    respExp_t  respQ[$];
    slaveCfg_t slaveQ[$];
    mreq_t     mq0[$];
    mreq_t     mq1[$];

    int checksDone = 0;
    int failCount  = 0;
    int cyc        = 0;
    int lastDone   = -10;
    int accCnt     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_master_arb #(
        .NMST (NMST),
        .AWID (AWID),
        .DWID (DWID),
        .TOUT (TOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_pstrb   (m_pstrb),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_presp   (m_presp),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .presp     (presp),
        .gnt       (gnt),
        .timeout   (timeout)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksDone++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic flagFail(input string name);
        checksDone++;
        failCount++;
        $display("[TB] FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
    endtask

    // Queue one transfer in grant order: master request, expected downstream
    // SETUP, slave behaviour and expected upstream response.
    task automatic queueXfer(input int m, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input int waitCyc, input logic [31:0] rdata,
                             input logic [1:0] resp, input bit expTo, input bit b2b);
        mreq_t      r;
        setupExp_t  s;
        slaveCfg_t  c;
        respExp_t   e;
        logic [1:0] oh;
        oh = (m == 0) ? 2'b01 : 2'b10;
        r  = '{wr: wr, addr: addr, wdata: wdata, strb: strb};
        if (m == 0) mq0.push_back(r);
        else        mq1.push_back(r);
        s = '{gnt: oh, b2b: b2b, wr: wr, addr: addr, wdata: wdata, strb: strb};
        setupQ.push_back(s);
        c = '{waitCyc: waitCyc, rdata: rdata, resp: resp};
        slaveQ.push_back(c);
        if (expTo)
            e = '{rdy: oh, rdata: 32'h0, resp: 2'b10, to: 1'b1, acc: TOUT, chkData: 1'b0};
        else
            e = '{rdy: oh, rdata: rdata, resp: resp, to: 1'b0, acc: waitCyc + 1, chkData: !wr};
        respQ.push_back(e);
    endtask

    // Upstream master i: drains its queue, going straight from one access phase
    // into the next setup phase when more work is pending.
    task automatic applyStimulus(input int i);
        mreq_t t;
        int    guard;
        @(posedge clk);
        #1;
        while ((i == 0) ? (mq0.size() > 0) : (mq1.size() > 0)) begin
            t = (i == 0) ? mq0.pop_front() : mq1.pop_front();
            m_psel[i]               = 1'b1;
            m_penable[i]            = 1'b0;
            m_pwrite[i]             = t.wr;
            m_paddr[i*AWID +: AWID] = t.addr;
            m_pwdata[i*DWID +: DWID] = t.wdata;
            m_pstrb[i*4 +: 4]       = t.strb;
            @(posedge clk);
            #1;
            m_penable[i] = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!m_pready[i] && guard < 60);
            if (!m_pready[i]) checkOutput($sformatf("m%0d_completion_wait", i), 64'(m_pready[i]), 64'd1);
            @(posedge clk);
            #1;
        end
        m_psel[i]    = 1'b0;
        m_penable[i] = 1'b0;
    endtask

    // Downstream slave: takes a config at SETUP and raises pready after the
    // programmed number of ACCESS wait cycles.
    initial begin
        slaveCfg_t cfg;
        int        cnt;
        pready = 1'b0;
        prdata = '0;
        presp  = 2'b00;
        cfg    = '{waitCyc: 0, rdata: 32'h0, resp: 2'b00};
        cnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && !penable) begin
                if (slaveQ.size() == 0) begin
                    flagFail("slave_cfg_missing");
                    cfg = '{waitCyc: 0, rdata: 32'h0, resp: 2'b00};
                end else begin
                    cfg = slaveQ.pop_front();
                end
                cnt    = 0;
                pready = 1'b0;
            end else if (psel && penable) begin
                pready = (cnt == cfg.waitCyc);
                prdata = cfg.rdata;
                presp  = cfg.resp;
                cnt++;
            end else begin
                pready = 1'b0;
            end
        end
    end

    // Monitor: checks every downstream SETUP and every upstream completion.
    initial begin
        setupExp_t s;
        respExp_t  e;
        forever begin
            @(negedge clk);
            if (psel && !penable) begin
                if (setupQ.size() == 0) begin
                    flagFail("unexpected_setup");
                end else begin
                    s = setupQ.pop_front();
                    checkOutput("setup_gnt", 64'(gnt), 64'(s.gnt));
                    checkOutput("setup_pwrite", 64'(pwrite), 64'(s.wr));
                    checkOutput("setup_paddr", 64'(paddr), 64'(s.addr));
                    if (s.wr) begin
                        checkOutput("setup_pwdata", 64'(pwdata), 64'(s.wdata));
                        checkOutput("setup_pstrb", 64'(pstrb), 64'(s.strb));
                    end
                    if (s.b2b) checkOutput("b2b_gap", 64'(cyc - lastDone), 64'd1);
                end
                accCnt = 0;
            end
            if (psel && penable) accCnt++;
            if (|m_pready) begin
                if (respQ.size() == 0) begin
                    flagFail("unexpected_pready");
                end else begin
                    e = respQ.pop_front();
                    checkOutput("resp_pready", 64'(m_pready), 64'(e.rdy));
                    checkOutput("resp_presp", 64'(m_presp), 64'(e.resp));
                    checkOutput("resp_timeout", 64'(timeout), 64'(e.to));
                    checkOutput("resp_access_cycles", 64'(accCnt), 64'(e.acc));
                    if (e.chkData) checkOutput("resp_prdata", 64'(m_prdata), 64'(e.rdata));
                end
                lastDone = cyc;
            end else if (timeout) begin
                flagFail("timeout_without_pready");
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: got no end of test, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        rst_n     = 1'b0;
        m_psel    = '0;
        m_penable = '0;
        m_pwrite  = '0;
        m_paddr   = '0;
        m_pwdata  = '0;
        m_pstrb   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_psel", 64'(psel), 64'd0);
        checkOutput("reset_penable", 64'(penable), 64'd0);
        checkOutput("reset_gnt", 64'(gnt), 64'd0);
        checkOutput("reset_m_pready", 64'(m_pready), 64'd0);
        checkOutput("reset_timeout", 64'(timeout), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single read, zero wait");
        queueXfer(0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hCAFE0001, 2'b00, 1'b0, 1'b0);
        fork
            applyStimulus(0);
            begin
                @(negedge clk);
                checkOutput("latency_idle_psel", 64'(psel), 64'd0);
                @(negedge clk);
                checkOutput("latency_setup", 64'({psel, penable}), 64'b10);
                @(negedge clk);
                checkOutput("latency_access", 64'({psel, penable}), 64'b11);
            end
        join

        $display("[TB] write with three wait states");
        queueXfer(1, 1'b1, 32'h20, 32'h55AA, 4'hF, 3, 32'h0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1);

        $display("[TB] simultaneous requests");
        queueXfer(0, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h11111111, 2'b00, 1'b0, 1'b0);
        queueXfer(1, 1'b0, 32'h204, 32'h0, 4'h0, 1, 32'h22222222, 2'b00, 1'b0, 1'b1);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        $display("[TB] fairness, eight continuous transfers");
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0)
                queueXfer(0, 1'b0, 32'h300 + 32'(4 * (j / 2)), 32'h0, 4'h0, j % 3,
                          32'hA0000000 + 32'(j / 2), 2'b00, 1'b0, j > 0);
            else
                queueXfer(1, 1'b1, 32'h400 + 32'(4 * (j / 2)), 32'hB0000000 + 32'(j / 2), 4'h3, j % 3,
                          32'h0, (j == 5) ? 2'b10 : 2'b00, 1'b0, 1'b1);
        end
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        $display("[TB] watchdog on a hung slave");
        queueXfer(0, 1'b0, 32'h500, 32'h0, 4'h0, 255, 32'h0, 2'b00, 1'b1, 1'b0);
        applyStimulus(0);
        @(negedge clk);
        checkOutput("psel_after_timeout", 64'(psel), 64'd0);

        $display("[TB] pready coinciding with watchdog limit");
        queueXfer(0, 1'b0, 32'h504, 32'h0, 4'h0, 3, 32'h0BADF00D, 2'b00, 1'b0, 1'b0);
        applyStimulus(0);

        $display("[TB] reset during ACCESS");
        setupQ.push_back('{gnt: 2'b10, b2b: 1'b0, wr: 1'b0, addr: 32'h700, wdata: 32'h0, strb: 4'h0});
        slaveQ.push_back('{waitCyc: 255, rdata: 32'h0, resp: 2'b00});
        @(posedge clk);
        #1;
        m_psel[1]        = 1'b1;
        m_pwrite[1]      = 1'b0;
        m_paddr[63:32]   = 32'h700;
        @(posedge clk);
        #1 m_penable[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("sync_reset_holds_access", 64'({psel, penable}), 64'b11);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        m_psel[1]    = 1'b0;
        m_penable[1] = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_psel", 64'(psel), 64'd0);
        checkOutput("after_reset_penable", 64'(penable), 64'd0);
        checkOutput("after_reset_gnt", 64'(gnt), 64'd0);
        checkOutput("after_reset_m_pready", 64'(m_pready), 64'd0);

        $display("[TB] arbitration restarts from master 0");
        queueXfer(0, 1'b0, 32'h800, 32'h0, 4'h0, 0, 32'h800D0000, 2'b00, 1'b0, 1'b0);
        queueXfer(1, 1'b0, 32'h804, 32'h0, 4'h0, 0, 32'h600DD00D, 2'b00, 1'b0, 1'b1);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        repeat (3) @(negedge clk);
        checkOutput("setup_queue_drained", 64'(setupQ.size()), 64'd0);
        checkOutput("resp_queue_drained", 64'(respQ.size()), 64'd0);
        checkOutput("slave_queue_drained", 64'(slaveQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checksDone, failCount);
        $finish;
    end

endmodule
